// File: rtl/hazard_pkg.sv
// Shared definitions for the MIPS hazard controller: forward-select encodings
// and the default MULT/DIV latencies used by the scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF      = 2'd0,
        FWD_RESULTW = 2'd1,
        FWD_ALUOUTM = 2'd2
    } fwd_sel_e;

    localparam int MUL_LATENCY_DEF    = 4;
    localparam int DIV_LATENCY_DEF    = 32;
    localparam int MD_CNT_WIDTH_DEF   = 6;
    localparam int PERF_CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/md_scoreboard.sv
// MULT/DIV scoreboard: counts down the cycles until HI/LO become valid and
// exposes a registered busy flag.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY  = MUL_LATENCY_DEF,
    parameter int DIV_LATENCY  = DIV_LATENCY_DEF,
    parameter int MD_CNT_WIDTH = MD_CNT_WIDTH_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_MdStartE,
    input  logic i_MdDivE,
    output logic o_MdBusy
);

    localparam logic [MD_CNT_WIDTH-1:0] MulLoad = MD_CNT_WIDTH'(MUL_LATENCY);
    localparam logic [MD_CNT_WIDTH-1:0] DivLoad = MD_CNT_WIDTH'(DIV_LATENCY);

    logic [MD_CNT_WIDTH-1:0] mdCnt_q;
    logic [MD_CNT_WIDTH-1:0] mdCnt_d;
    logic                    mdBusy_q;
    logic                    mdBusy_d;

    // A new start reloads the counter (even while busy); otherwise count down
    // to zero independently of any pipeline stall.
    always_comb begin
        mdCnt_d = mdCnt_q;
        if (i_MdStartE) begin
            mdCnt_d = i_MdDivE ? DivLoad : MulLoad;
        end else if (mdCnt_q != '0) begin
            mdCnt_d = mdCnt_q - 1'b1;
        end
        mdBusy_d = (mdCnt_d != '0);
    end

    // Counter and busy flag registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mdCnt_q  <= '0;
            mdBusy_q <= 1'b0;
        end else begin
            mdCnt_q  <= mdCnt_d;
            mdBusy_q <= mdBusy_d;
        end
    end

    assign o_MdBusy = mdBusy_q;

endmodule

// File: rtl/hazard_unit_md.sv
// Hazard controller for the 5-stage MIPS core: operand forwarding, load-use,
// branch/JR and MULT/DIV stalls, plus a saturating stall-cycle counter.
module hazard_unit_md
    import hazard_pkg::*;
#(
    parameter int RF_ADDR_WIDTH  = 5,
    parameter int MUL_LATENCY    = MUL_LATENCY_DEF,
    parameter int DIV_LATENCY    = DIV_LATENCY_DEF,
    parameter int MD_CNT_WIDTH   = MD_CNT_WIDTH_DEF,
    parameter int PERF_CNT_WIDTH = PERF_CNT_WIDTH_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_BranchD,
    input  logic                      i_JrD,
    input  logic                      i_JD,
    input  logic                      i_ALUSrcD,
    input  logic                      i_MdStartD,
    input  logic                      i_MfhiloD,
    input  logic                      i_MdStartE,
    input  logic                      i_MdDivE,
    input  logic [RF_ADDR_WIDTH-1:0]  i_RsD,
    input  logic [RF_ADDR_WIDTH-1:0]  i_RtD,
    input  logic [RF_ADDR_WIDTH-1:0]  i_RsE,
    input  logic [RF_ADDR_WIDTH-1:0]  i_RtE,
    input  logic [RF_ADDR_WIDTH-1:0]  i_WriteRegE,
    input  logic [RF_ADDR_WIDTH-1:0]  i_WriteRegM,
    input  logic [RF_ADDR_WIDTH-1:0]  i_WriteRegW,
    input  logic                      i_RegWriteE,
    input  logic                      i_RegWriteM,
    input  logic                      i_RegWriteW,
    input  logic                      i_MemtoRegE,
    input  logic                      i_MemtoRegM,
    input  logic                      i_MemtoRegW,
    output logic                      o_StallF,
    output logic                      o_StallD,
    output logic                      o_FlushE,
    output logic                      o_ForwardAD,
    output logic                      o_ForwardBD,
    output logic [1:0]                o_ForwardAE,
    output logic [1:0]                o_ForwardBE,
    output logic                      o_MemDataSelM,
    output logic                      o_MdBusy,
    output logic [PERF_CNT_WIDTH-1:0] o_StallCount
);

    fwd_sel_e                  fwdAE;
    fwd_sel_e                  fwdBE;
    logic                      rsDNz;
    logic                      rtDNz;
    logic                      lwStall;
    logic                      branchStall;
    logic                      jrStall;
    logic                      mdStall;
    logic                      stall;
    logic [PERF_CNT_WIDTH-1:0] stallCount_q;
    logic [PERF_CNT_WIDTH-1:0] stallCount_d;

    md_scoreboard #(
        .MUL_LATENCY  (MUL_LATENCY),
        .DIV_LATENCY  (DIV_LATENCY),
        .MD_CNT_WIDTH (MD_CNT_WIDTH)
    ) u_md_scoreboard (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_MdStartE (i_MdStartE),
        .i_MdDivE   (i_MdDivE),
        .o_MdBusy   (o_MdBusy)
    );

    // EX-stage ALU forwarding: the younger M-stage result wins over W.
    always_comb begin
        fwdAE = FWD_RF;
        if (i_RsE != '0 && i_RegWriteM && i_RsE == i_WriteRegM) begin
            fwdAE = FWD_ALUOUTM;
        end else if (i_RsE != '0 && i_RegWriteW && i_RsE == i_WriteRegW) begin
            fwdAE = FWD_RESULTW;
        end
        fwdBE = FWD_RF;
        if (i_RtE != '0 && i_RegWriteM && i_RtE == i_WriteRegM) begin
            fwdBE = FWD_ALUOUTM;
        end else if (i_RtE != '0 && i_RegWriteW && i_RtE == i_WriteRegW) begin
            fwdBE = FWD_RESULTW;
        end
    end

    assign o_ForwardAE = fwdAE;
    assign o_ForwardBE = fwdBE;

    assign rsDNz = (i_RsD != '0);
    assign rtDNz = (i_RtD != '0);

    // Decode-stage comparator forwarding from ALUOutM for branches and JR.
    assign o_ForwardAD = i_RegWriteM && rsDNz && (i_RsD == i_WriteRegM);
    assign o_ForwardBD = i_RegWriteM && rtDNz && (i_RtD == i_WriteRegM);

    // Store data comes from ResultW when a load in W feeds the store in M.
    assign o_MemDataSelM = i_MemtoRegW && (i_WriteRegM == i_WriteRegW);

    // Stall causes; a reset in progress releases the MULT/DIV stall at once.
    always_comb begin
        lwStall = i_MemtoRegE && !i_JD &&
                  ((rsDNz && i_RsD == i_RtE) ||
                   (rtDNz && i_RtD == i_RtE && !i_ALUSrcD && !i_JrD));
        branchStall = i_BranchD &&
                      ((i_RegWriteE && ((rsDNz && i_RsD == i_WriteRegE) ||
                                        (rtDNz && i_RtD == i_WriteRegE))) ||
                       (i_MemtoRegM && ((rsDNz && i_RsD == i_WriteRegM) ||
                                        (rtDNz && i_RtD == i_WriteRegM))));
        jrStall = i_JrD && rsDNz &&
                  ((i_RegWriteE && i_RsD == i_WriteRegE) ||
                   (i_MemtoRegM && i_RsD == i_WriteRegM));
        mdStall = i_rst_n && (i_MdStartD || i_MfhiloD) &&
                  (o_MdBusy || i_MdStartE);
        stall = lwStall || branchStall || jrStall || mdStall;
    end

    assign o_StallF = stall;
    assign o_StallD = stall;
    assign o_FlushE = stall;

    // Stall-cycle counter saturates at all-ones instead of wrapping.
    always_comb begin
        stallCount_d = stallCount_q;
        if (stall && !(&stallCount_q)) begin
            stallCount_d = stallCount_q + 1'b1;
        end
    end

    // Performance counter register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

    assign o_StallCount = stallCount_q;

endmodule

// File: tb/tb_hazard_unit_md.sv
// Self-checking bench for hazard_unit_md: directed scenarios plus randomized
// cycles compared against a timeline-based behavioural model.
module tb_hazard_unit_md;

    logic        clk;
    logic        rst_n;
    logic        BranchD, JrD, JD, ALUSrcD, MdStartD, MfhiloD, MdStartE, MdDivE;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemtoRegW;
    logic        StallF, StallD, FlushE, ForwardAD, ForwardBD, MemDataSelM, MdBusy;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    int checks = 0;
    int errors = 0;

    // Model state: cycle index, most recent MULT/DIV start and its latency,
    // and the number of stalled cycles seen since reset.
    int cycleNum     = 0;
    int mdStartCycle = -1000;
    int mdLat        = 0;
    int stallModel   = 0;

    hazard_unit_md dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_BranchD     (BranchD),
        .i_JrD         (JrD),
        .i_JD          (JD),
        .i_ALUSrcD     (ALUSrcD),
        .i_MdStartD    (MdStartD),
        .i_MfhiloD     (MfhiloD),
        .i_MdStartE    (MdStartE),
        .i_MdDivE      (MdDivE),
        .i_RsD         (RsD),
        .i_RtD         (RtD),
        .i_RsE         (RsE),
        .i_RtE         (RtE),
        .i_WriteRegE   (WriteRegE),
        .i_WriteRegM   (WriteRegM),
        .i_WriteRegW   (WriteRegW),
        .i_RegWriteE   (RegWriteE),
        .i_RegWriteM   (RegWriteM),
        .i_RegWriteW   (RegWriteW),
        .i_MemtoRegE   (MemtoRegE),
        .i_MemtoRegM   (MemtoRegM),
        .i_MemtoRegW   (MemtoRegW),
        .o_StallF      (StallF),
        .o_StallD      (StallD),
        .o_FlushE      (FlushE),
        .o_ForwardAD   (ForwardAD),
        .o_ForwardBD   (ForwardBD),
        .o_ForwardAE   (ForwardAE),
        .o_ForwardBE   (ForwardBE),
        .o_MemDataSelM (MemDataSelM),
        .o_MdBusy      (MdBusy),
        .o_StallCount  (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // HI/LO is pending for the LATENCY cycles following the start cycle.
    function automatic logic modelBusy();
        return (cycleNum > mdStartCycle) && (cycleNum <= mdStartCycle + mdLat);
    endfunction

    function automatic logic [1:0] expFwdE(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (RegWriteM && src == WriteRegM) return 2'd2;
        if (RegWriteW && src == WriteRegW) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic expFwdD(input logic [4:0] src);
        return RegWriteM && src != 5'd0 && src == WriteRegM;
    endfunction

    function automatic logic hitsE(input logic [4:0] src);
        return RegWriteE && src != 5'd0 && src == WriteRegE;
    endfunction

    function automatic logic hitsLoadM(input logic [4:0] src);
        return MemtoRegM && src != 5'd0 && src == WriteRegM;
    endfunction

    function automatic logic expStall();
        logic lw, br, jr, md;
        lw = MemtoRegE && !JD &&
             ((RsD != 5'd0 && RsD == RtE) ||
              (RtD != 5'd0 && RtD == RtE && !ALUSrcD && !JrD));
        br = BranchD && (hitsE(RsD) || hitsE(RtD) || hitsLoadM(RsD) || hitsLoadM(RtD));
        jr = JrD && (hitsE(RsD) || hitsLoadM(RsD));
        md = rst_n && (MdStartD || MfhiloD) && (modelBusy() || MdStartE);
        return lw || br || jr || md;
    endfunction

    // Advance one clock: update the model from the pre-edge inputs, then
    // return just after the edge so new stimulus can be applied.
    task automatic clockEdge();
        logic st;
        st = expStall();
        @(posedge clk);
        if (!rst_n) begin
            stallModel   = 0;
            mdStartCycle = -1000;
        end else begin
            if (st && stallModel < 65535) stallModel++;
            if (MdStartE) begin
                mdStartCycle = cycleNum;
                mdLat        = MdDivE ? 32 : 4;
            end
        end
        cycleNum++;
        #1;
    endtask

    task automatic clearInputs();
        {BranchD, JrD, JD, ALUSrcD, MdStartD, MfhiloD, MdStartE, MdDivE} = '0;
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemtoRegW} = '0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst_n = 1'b0;
        clockEdge();
        clockEdge();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushE, MdBusy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {StallF, StallD, FlushE, MdBusy});
        end
        checks++;
        if (StallCount !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", StallCount);
        end
        checks++;
        if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_fwd: got %b expected 000000", {ForwardAE, ForwardBE, ForwardAD, ForwardBD});
        end
        clockEdge();
    endtask

    task automatic test_forward_e();
        clearInputs();
        RegWriteM = 1'b1; WriteRegM = 5'd3;
        RegWriteW = 1'b1; WriteRegW = 5'd3;
        RsE = 5'd3;
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'd2) begin
            errors++;
            $display("[TB] FAIL fwdAE_m_priority: got %0d expected 2", ForwardAE);
        end
        RegWriteM = 1'b0;
        #1;
        checks++;
        if (ForwardAE !== 2'd1) begin
            errors++;
            $display("[TB] FAIL fwdAE_w_only: got %0d expected 1", ForwardAE);
        end
        RsE = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd0; WriteRegW = 5'd0;
        #1;
        checks++;
        if (ForwardAE !== 2'd0) begin
            errors++;
            $display("[TB] FAIL fwdAE_r0: got %0d expected 0", ForwardAE);
        end
        clockEdge();
    endtask

    task automatic test_lwstall();
        clearInputs();
        MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL lwstall: got %b expected 111", {StallF, StallD, FlushE});
        end
        JD = 1'b1;
        #1;
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL lwstall_jump: got %b expected 000", {StallF, StallD, FlushE});
        end
        JD = 1'b0;
        clockEdge();
        MemtoRegE = 1'b0; RtE = 5'd0;
        @(negedge clk);
        checks++;
        if (StallD !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lwstall_one_cycle: got %b expected 0", StallD);
        end
        clockEdge();
    endtask

    task automatic test_branch();
        clearInputs();
        BranchD = 1'b1; RsD = 5'd4; RegWriteE = 1'b1; WriteRegE = 5'd4;
        @(negedge clk);
        checks++;
        if (StallD !== 1'b1) begin
            errors++;
            $display("[TB] FAIL branch_stall_e: got %b expected 1", StallD);
        end
        clockEdge();
        RegWriteE = 1'b0; WriteRegE = 5'd0;
        RegWriteM = 1'b1; WriteRegM = 5'd4; MemtoRegM = 1'b0;
        @(negedge clk);
        checks++;
        if ({StallD, ForwardAD} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL branch_fwd_m: got %b expected 01", {StallD, ForwardAD});
        end
        MemtoRegM = 1'b1;
        #1;
        checks++;
        if (StallD !== 1'b1) begin
            errors++;
            $display("[TB] FAIL branch_load_m: got %b expected 1", StallD);
        end
        clockEdge();
    endtask

    task automatic test_div();
        clearInputs();
        for (int i = 0; i <= 34; i++) begin
            MdStartE = (i == 0);
            MdDivE   = 1'b1;
            MfhiloD  = 1'b1;
            @(negedge clk);
            checks++;
            if ({StallD, MdBusy} !== {1'(i <= 32), 1'(i >= 1 && i <= 32)}) begin
                errors++;
                $display("[TB] FAIL div_cycle_%0d: got stall/busy %b expected %b", i,
                         {StallD, MdBusy}, {1'(i <= 32), 1'(i >= 1 && i <= 32)});
            end
            clockEdge();
        end
        clearInputs();
    endtask

    task automatic test_mult_reload();
        clearInputs();
        for (int i = 0; i <= 5; i++) begin
            MdStartE = (i == 0);
            MdStartD = 1'b1;
            @(negedge clk);
            checks++;
            if (StallD !== 1'(i <= 4)) begin
                errors++;
                $display("[TB] FAIL mult_dep_cycle_%0d: got %b expected %b", i, StallD, 1'(i <= 4));
            end
            clockEdge();
        end
        // The released MULT now starts in EX; busy is restarted, then a third
        // start two cycles in, while still busy, reloads the full latency.
        MdStartD = 1'b0;
        MdStartE = 1'b1;
        clockEdge();
        MdStartE = 1'b0;
        clockEdge();
        for (int i = 0; i <= 5; i++) begin
            MdStartE = (i == 0);
            @(negedge clk);
            checks++;
            if (MdBusy !== 1'(i <= 4)) begin
                errors++;
                $display("[TB] FAIL mult_reload_%0d: got %b expected %b", i, MdBusy, 1'(i <= 4));
            end
            clockEdge();
        end
        clearInputs();
    endtask

    task automatic test_random();
        logic [1:0] eAE, eBE;
        logic       eAD, eBD, eSt, eSel;
        for (int n = 0; n < 400; n++) begin
            BranchD   = ($urandom_range(0, 3) == 0);
            JrD       = ($urandom_range(0, 5) == 0);
            JD        = ($urandom_range(0, 5) == 0);
            ALUSrcD   = 1'($urandom);
            MdStartD  = ($urandom_range(0, 5) == 0);
            MfhiloD   = ($urandom_range(0, 5) == 0);
            MdStartE  = ($urandom_range(0, 11) == 0);
            MdDivE    = ($urandom_range(0, 3) == 0);
            RsD       = 5'($urandom_range(0, 7));
            RtD       = 5'($urandom_range(0, 7));
            RsE       = 5'($urandom_range(0, 7));
            RtE       = 5'($urandom_range(0, 7));
            WriteRegE = 5'($urandom_range(0, 7));
            WriteRegM = 5'($urandom_range(0, 7));
            WriteRegW = 5'($urandom_range(0, 7));
            RegWriteE = 1'($urandom);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            MemtoRegE = ($urandom_range(0, 2) == 0);
            MemtoRegM = ($urandom_range(0, 2) == 0);
            MemtoRegW = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            eAE  = expFwdE(RsE);
            eBE  = expFwdE(RtE);
            eAD  = expFwdD(RsD);
            eBD  = expFwdD(RtD);
            eSt  = expStall();
            eSel = MemtoRegW && WriteRegM == WriteRegW;
            checks++;
            if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemDataSelM} !== {eAE, eBE, eAD, eBD, eSel}) begin
                errors++;
                $display("[TB] FAIL rand_fwd_%0d: got %b expected %b", n,
                         {ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemDataSelM}, {eAE, eBE, eAD, eBD, eSel});
            end
            checks++;
            if ({StallF, StallD, FlushE, MdBusy} !== {eSt, eSt, eSt, modelBusy()}) begin
                errors++;
                $display("[TB] FAIL rand_stall_%0d: got %b expected %b", n,
                         {StallF, StallD, FlushE, MdBusy}, {eSt, eSt, eSt, modelBusy()});
            end
            checks++;
            if (StallCount !== 16'(stallModel)) begin
                errors++;
                $display("[TB] FAIL rand_count_%0d: got %0d expected %0d", n, StallCount, stallModel);
            end
            clockEdge();
        end
        clearInputs();
        for (int i = 0; i < 40; i++) clockEdge();
    endtask

    task automatic test_saturation();
        clearInputs();
        MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
        for (int i = 0; i < 70000; i++) clockEdge();
        @(negedge clk);
        checks++;
        if (StallCount !== 16'd65535 || stallModel != 65535) begin
            errors++;
            $display("[TB] FAIL stall_saturate: got %0d expected 65535 (model %0d)", StallCount, stallModel);
        end
        clockEdge();
        @(negedge clk);
        checks++;
        if (StallCount !== 16'd65535) begin
            errors++;
            $display("[TB] FAIL stall_saturate_hold: got %0d expected 65535", StallCount);
        end
        clearInputs();
        clockEdge();
    endtask

    task automatic test_reset_mid_div();
        clearInputs();
        MdStartE = 1'b1; MdDivE = 1'b1;
        clockEdge();
        MdStartE = 1'b0; MfhiloD = 1'b1;
        for (int i = 0; i < 5; i++) clockEdge();
        @(negedge clk);
        checks++;
        if ({StallD, MdBusy} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL mid_div_busy: got %b expected 11", {StallD, MdBusy});
        end
        rst_n = 1'b0;
        clockEdge();
        @(negedge clk);
        checks++;
        if ({StallD, MdBusy} !== 2'b00 || StallCount !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_div_reset: got stall/busy %b count %0d expected 00 count 0",
                     {StallD, MdBusy}, StallCount);
        end
        clockEdge();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({StallD, MdBusy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL after_reset_release: got %b expected 00", {StallD, MdBusy});
        end
        clockEdge();
    endtask

    // Scenario sequence.
    initial begin
        rst_n = 1'b0;
        clearInputs();
        test_reset();
        test_forward_e();
        test_lwstall();
        test_branch();
        test_div();
        test_mult_reload();
        test_random();
        test_saturation();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
